us96_rep: RTL
=============

Name: us96_rep

Overview:
- Nearest-neighbour upscaler for one 8-bit colour channel. It is the inverse of the 96-point downscaler.
- Consumes a raster-order SRC_W x SRC_H stream (default 96x96) and emits a DST_W x DST_H stream (default 256x256) by pixel and line replication.
- Three instances, one per R/G/B channel, sit between the channel separator and the channel compressor in the restore path.
- Valid/ready handshake on both sides.

Parameters:
- DW, 8, channel data width.
- SRC_W, 96, source pixels per line; must be <= DST_W.
- SRC_H, 96, source lines per frame; must be <= DST_H.
- DST_W, 256, output pixels per line.
- DST_H, 256, output lines per frame.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DW  source pixel.
- din_valid  in  1  din holds a valid pixel.
- din_ready  out  1  block accepts din this cycle.
- dout  out  DW  output pixel, registered.
- dout_valid  out  1  dout valid, registered.
- dout_ready  in  1  sink accepts dout this cycle.
- dout_eol  out  1  dout is the last pixel of an output line (x_out = DST_W-1), registered.
- dout_last  out  1  dout is the last pixel of the frame (x_out = DST_W-1 and y_out = DST_H-1), registered.

Behaviour:
- Reset values: dout = 0, dout_valid = 0, dout_eol = 0, dout_last = 0. All counters and accumulators are 0. The line buffer is not reset.
- Source mapping:
  - x_src(x) = floor(x*SRC_W/DST_W), computed incrementally with an x accumulator xacc in [0, DST_W).
  - Per output pixel: xacc += SRC_W; if the sum >= DST_W, subtract DST_W and increment x_src.
  - y uses the same scheme (yacc, y_src), stepping at end of line.
  - No multipliers.
- Column classes:
  - new column: x_out = 0, or x_src changed on this step.
  - Every other column is a repeat column.
- Row classes:
  - fetch row: y_out = 0, or y_src changed on this step.
  - Every other row is a repeat row.
- Advance condition: the position (x_out, y_out) advances when the output register is free, i.e. !dout_valid or dout_ready.
- Fetch row, new column:
  - din_ready = free.
  - On the din_valid & din_ready cycle: dout <= din, hold_reg <= din, linebuf[x_src] <= din, dout_valid <= 1, position advances.
  - If din_valid = 0, the output register drains and the position does not advance.
- Fetch row, repeat column: din_ready = 0; dout <= hold_reg when free.
- Repeat row: din_ready = 0; dout <= linebuf[x_src] when free.
  - linebuf is a DST-independent SRC_W x DW register array with combinational read.
- When free and no load occurs, dout_valid <= 0.
- din_ready is combinational from dout_ready and state. No other combinational in-to-out path exists.
- Latency: din accepted at edge N appears on dout after edge N; replicated pixels follow back-to-back while dout_ready = 1.
- Throughput: one output per cycle under full flow.
- Each frame consumes exactly SRC_W*SRC_H inputs and produces DST_W*DST_H outputs (defaults: 9216 in, 65536 out).
  - Default pattern per 8 outputs: source 0,0,0,1,1,1,2,2 (3 sources).
  - Default frame: 96 fetch rows, 160 repeat rows.
- Wrap-around: after the output pixel with dout_last is loaded, x_out, y_out, xacc, yacc, x_src and y_src return to 0. The next frame starts with no bubble.
- Flags: dout_eol and dout_last are loaded with the same pixel they tag and are held with dout while stalled.
- Backpressure: while dout_valid & !dout_ready, dout, dout_eol, dout_last and all counters hold; din_ready = 0.
- Reset mid-frame: immediate return to the reset state. Partial frames are discarded and the next input pixel is treated as source (0,0).

Test Plan:
1. Defaults, din = column index for each source line (0..95), dout_ready = 1 -> output line 0, pixels 0..7 = 00,00,00,01,01,01,02,02; pixel 255 = 5F with dout_eol = 1.
2. din = 16*(row mod 16) + (col mod 16) -> output lines 0,1,2 identical. Line 3 pixel 0 = 10 and line 3 consumes input. Lines 1,2 assert din_ready = 0 throughout.
3. Random dout_ready (50%) and random din_valid gaps -> output sequence is bit-identical to the case 1/2 golden model. No duplicated or dropped pixels. dout stable while stalled.
4. Two back-to-back frames -> exactly 65536 outputs and 9216 accepted inputs per frame. dout_last is asserted only on output 65535 and output 131071. Second frame pixel 0 = first input of frame 2.
5. Assert rst_n = 0 for one cycle at output pixel ~30000, then restart a frame -> all outputs are 0 immediately. A full correct 65536-pixel frame follows.
6. Parameter override SRC_W = 2, DST_W = 5, SRC_H = 2, DST_H = 3, din = 1,2,3,4 -> rows: 1,1,1,2,2 / 1,1,1,2,2 / 3,3,3,4,4.

Source files
------------

// File: rtl/us96_rep.sv
// Nearest-neighbour upscaler for one colour channel: replicates SRC_W x SRC_H raster
// pixels into a DST_W x DST_H raster using incremental accumulators and a one-line buffer.
module us96_rep #(
    parameter int DW    = 8,
    parameter int SRC_W = 96,
    parameter int SRC_H = 96,
    parameter int DST_W = 256,
    parameter int DST_H = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_eol,
    output logic          dout_last
);
    localparam int XW  = (DST_W > 1) ? $clog2(DST_W) : 1;
    localparam int YW  = (DST_H > 1) ? $clog2(DST_H) : 1;
    localparam int XSW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YSW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

    logic [XW-1:0]  x_out_q, x_out_d, xacc_q, xacc_d;
    logic [YW-1:0]  y_out_q, y_out_d, yacc_q, yacc_d;
    logic [XSW-1:0] x_src_q, x_src_d;
    logic [YSW-1:0] y_src_q, y_src_d;
    logic           new_col_q, new_col_d, fetch_row_q, fetch_row_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d, dout_eol_q, dout_eol_d, dout_last_q, dout_last_d;

    // Data-only storage; every location is written in a fetch row before any repeat row reads it.
    logic [DW-1:0]  hold_q;
    logic [DW-1:0]  linebuf_q [SRC_W];

    logic           free, fetch_new, load, take, at_eol, at_last;
    logic [DW-1:0]  load_data;
    logic [XW:0]    xsum;
    logic [YW:0]    ysum;

    always_comb begin
        x_out_d      = x_out_q;
        xacc_d       = xacc_q;
        x_src_d      = x_src_q;
        new_col_d    = new_col_q;
        y_out_d      = y_out_q;
        yacc_d       = yacc_q;
        y_src_d      = y_src_q;
        fetch_row_d  = fetch_row_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_eol_d   = dout_eol_q;
        dout_last_d  = dout_last_q;
        load         = 1'b0;
        load_data    = '0;

        at_eol    = (x_out_q == XW'(DST_W - 1));
        at_last   = at_eol && (y_out_q == YW'(DST_H - 1));
        xsum      = {1'b0, xacc_q} + (XW+1)'(SRC_W);
        ysum      = {1'b0, yacc_q} + (YW+1)'(SRC_H);
        free      = !dout_valid_q || dout_ready;
        fetch_new = fetch_row_q && new_col_q;
        din_ready = free && fetch_new;

        if (fetch_new) begin
            load      = din_valid && din_ready;
            load_data = din;
        end else begin
            load      = free;
            load_data = fetch_row_q ? hold_q : linebuf_q[x_src_q];
        end
        take = fetch_new && load;

        if (free) begin
            dout_valid_d = load;
            if (load) begin
                dout_d      = load_data;
                dout_eol_d  = at_eol;
                dout_last_d = at_last;
                if (at_last) begin
                    x_out_d     = '0;
                    xacc_d      = '0;
                    x_src_d     = '0;
                    new_col_d   = 1'b1;
                    y_out_d     = '0;
                    yacc_d      = '0;
                    y_src_d     = '0;
                    fetch_row_d = 1'b1;
                end else if (at_eol) begin
                    x_out_d   = '0;
                    xacc_d    = '0;
                    x_src_d   = '0;
                    new_col_d = 1'b1;
                    y_out_d   = y_out_q + YW'(1);
                    // A row fetches new source data only when the y accumulator wraps.
                    if (ysum >= (YW+1)'(DST_H)) begin
                        yacc_d      = YW'(ysum - (YW+1)'(DST_H));
                        y_src_d     = y_src_q + YSW'(1);
                        fetch_row_d = 1'b1;
                    end else begin
                        yacc_d      = YW'(ysum);
                        fetch_row_d = 1'b0;
                    end
                end else begin
                    x_out_d = x_out_q + XW'(1);
                    if (xsum >= (XW+1)'(DST_W)) begin
                        xacc_d    = XW'(xsum - (XW+1)'(DST_W));
                        x_src_d   = x_src_q + XSW'(1);
                        new_col_d = 1'b1;
                    end else begin
                        xacc_d    = XW'(xsum);
                        new_col_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out_q      <= '0;
            xacc_q       <= '0;
            x_src_q      <= '0;
            new_col_q    <= 1'b1;
            y_out_q      <= '0;
            yacc_q       <= '0;
            y_src_q      <= '0;
            fetch_row_q  <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_eol_q   <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            x_out_q      <= x_out_d;
            xacc_q       <= xacc_d;
            x_src_q      <= x_src_d;
            new_col_q    <= new_col_d;
            y_out_q      <= y_out_d;
            yacc_q       <= yacc_d;
            y_src_q      <= y_src_d;
            fetch_row_q  <= fetch_row_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_eol_q   <= dout_eol_d;
            dout_last_q  <= dout_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            hold_q             <= din;
            linebuf_q[x_src_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_eol   = dout_eol_q;
    assign dout_last  = dout_last_q;
endmodule
